// File: rtl/wb_mem_pkg.sv
// Shared encodings and helpers for the MEM/WB segment with integrated data RAM.
// Store sizes, load types, the load-latency FSM states, the byte-lane mask
// generator and the load extension function used on the W side.
package wb_mem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_B    = 2'd1,
    MEM_H    = 2'd2,
    MEM_W    = 2'd3
  } st_size_e;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LB      = 3'd1,
    LH      = 3'd2,
    LW      = 3'd3,
    LBU     = 3'd4,
    LHU     = 3'd5
  } ld_type_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } lat_state_e;

  // Byte-lane write enables for a store of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      MEM_B:   m = 4'b0001;
      MEM_H:   m = 4'b0011;
      MEM_W:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m << off;
  endfunction

  // Select the addressed byte/half from a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] typ);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (typ)
      LB:      r = {{24{sh[7]}}, sh[7:0]};
      LBU:     r = {24'd0, sh[7:0]};
      LH:      r = {{16{sh[15]}}, sh[15:0]};
      LHU:     r = {16'd0, sh[15:0]};
      LW:      r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dp_bram_be.sv
// True-dual-port 32-bit RAM with per-byte write enables and synchronous read.
// Port A read latency is RD_LAT (1 or 2); port B read latency is 1.
// Ports: clk; we_a/addr_a/wdata_a/rdata_a; we_b/addr_b/wdata_b/rdata_b.
// Reads return the word as it was before a same-edge write (read-first).
// When both ports write the same byte on the same edge, port A wins.
module dp_bram_be #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic [3:0]        we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [31:0]       wdata_a,
  output logic [31:0]       rdata_a,
  input  logic [3:0]        we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [31:0]       wdata_b,
  output logic [31:0]       rdata_b
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] qa_p1;
  logic [31:0] qb_p1;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
      if (we_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
    end
    qa_p1 <= mem[addr_a];
    qb_p1 <= mem[addr_b];
  end

  // Optional second output register on port A
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [31:0] qa_p2;
      always_ff @(posedge clk) qa_p2 <= qa_p1;
      assign rdata_a = qa_p2;
    end else begin : g_lat1
      assign rdata_a = qa_p1;
    end
  endgenerate

  assign rdata_b = qb_p1;

endmodule

// File: rtl/wb_seg_mem.sv
// MEM/WB segment register with integrated dual-port data RAM.
// Inputs: clk, rst, en (0 = hold), clear (flush when en=1), MEM-stage access
//   (addr_m, wdata_m, store_m, load_m) and pass-through (result_m, rd_m,
//   regwrite_m), debug port (addr_dbg, wdata_dbg, we_dbg).
// Outputs: rdata_dbg, busy (load in flight, RD_LAT=2), WB-side result_w,
//   rd_w, regwrite_w, misalign_w.
module wb_seg_mem
  import wb_mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1,
  parameter int DBG_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic [1:0]  store_m,
  input  logic [2:0]  load_m,
  input  logic [31:0] result_m,
  input  logic [4:0]  rd_m,
  input  logic        regwrite_m,
  input  logic [31:0] addr_dbg,
  input  logic [31:0] wdata_dbg,
  input  logic [3:0]  we_dbg,
  output logic [31:0] rdata_dbg,
  output logic        busy,
  output logic [31:0] result_w,
  output logic [4:0]  rd_w,
  output logic        regwrite_w,
  output logic        misalign_w
);

  // Replicate store data across the word so every lane offset sees it.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      MEM_B:   return {4{data[7:0]}};
      MEM_H:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  logic [1:0]        off_m;
  logic [ADDR_W-1:0] waddr_m;
  logic              is_load_m;
  logic              mis_m;
  logic [3:0]        we_a;
  logic [31:0]       rdata_a;
  logic [3:0]        we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [31:0]       wdata_b;
  logic [31:0]       rdata_b;

  lat_state_e state, state_nx;
  logic accept, commit_m, commit_pend, flush_w;

  // Pending load parked while the second RAM stage completes
  logic [31:0] res_p1;
  logic [4:0]  rd_p1;
  logic        rw_p1;
  logic        mis_p1;
  logic [2:0]  ld_p1;
  logic [1:0]  off_p1;

  // W-side registers
  logic [31:0] res_p2;
  logic [2:0]  ld_p2;
  logic [1:0]  off_p2;
  logic        vld_p2;
  logic [31:0] hold_p2;
  logic [31:0] ext_now;

  assign off_m     = addr_m[1:0];
  assign waddr_m   = addr_m[ADDR_W+1:2];
  assign is_load_m = (load_m != LD_NONE);

  always_comb begin
    mis_m = 1'b0;
    if ((store_m == MEM_H) && off_m[0])                   mis_m = 1'b1;
    if ((store_m == MEM_W) && (off_m != 2'd0))            mis_m = 1'b1;
    if (((load_m == LH) || (load_m == LHU)) && off_m[0])  mis_m = 1'b1;
    if ((load_m == LW) && (off_m != 2'd0))                mis_m = 1'b1;
  end

  // Latency FSM: a load in RD_LAT=2 parks in WAIT for one cycle; W commits on exit.
  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    accept      = 1'b0;
    commit_m    = 1'b0;
    commit_pend = 1'b0;
    flush_w     = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          if (clear) begin
            flush_w = 1'b1;
          end else begin
            accept = 1'b1;
            if ((RD_LAT == 2) && is_load_m) state_nx = S_WAIT;
            else                            commit_m = 1'b1;
          end
        end
      end
      S_WAIT: begin
        busy     = 1'b1;
        state_nx = S_IDLE;
        if (clear) flush_w     = 1'b1;
        else       commit_pend = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  assign we_a = (accept && !mis_m && !rst) ? lane_mask(store_m, off_m) : 4'b0000;

  generate
    if (DBG_EN != 0) begin : g_dbg
      assign we_b      = we_dbg;
      assign addr_b    = addr_dbg[ADDR_W+1:2];
      assign wdata_b   = wdata_dbg;
      assign rdata_dbg = rdata_b;
    end else begin : g_nodbg
      assign we_b      = 4'b0000;
      assign addr_b    = '0;
      assign wdata_b   = 32'd0;
      assign rdata_dbg = 32'd0;
    end
  endgenerate

  dp_bram_be #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk     (clk),
    .we_a    (we_a),
    .addr_a  (waddr_m),
    .wdata_a (store_lanes(store_m, wdata_m)),
    .rdata_a (rdata_a),
    .we_b    (we_b),
    .addr_b  (addr_b),
    .wdata_b (wdata_b),
    .rdata_b (rdata_b)
  );

  // MEM -> pending stage
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1 <= 32'd0;
      rd_p1  <= 5'd0;
      rw_p1  <= 1'b0;
      mis_p1 <= 1'b0;
      ld_p1  <= LD_NONE;
      off_p1 <= 2'd0;
    end else if (accept) begin
      res_p1 <= result_m;
      rd_p1  <= rd_m;
      rw_p1  <= regwrite_m & ~(is_load_m & mis_m);
      mis_p1 <= mis_m;
      ld_p1  <= mis_m ? LD_NONE : load_m;
      off_p1 <= off_m;
    end
  end

  // MEM/pending -> W stage
  always_ff @(posedge clk) begin
    if (rst || flush_w) begin
      res_p2     <= 32'd0;
      rd_w       <= 5'd0;
      regwrite_w <= 1'b0;
      misalign_w <= 1'b0;
      ld_p2      <= LD_NONE;
      off_p2     <= 2'd0;
    end else if (commit_m) begin
      res_p2     <= result_m;
      rd_w       <= rd_m;
      regwrite_w <= regwrite_m & ~(is_load_m & mis_m);
      misalign_w <= mis_m;
      ld_p2      <= mis_m ? LD_NONE : load_m;
      off_p2     <= off_m;
    end else if (commit_pend) begin
      res_p2     <= res_p1;
      rd_w       <= rd_p1;
      regwrite_w <= rw_p1;
      misalign_w <= mis_p1;
      ld_p2      <= ld_p1;
      off_p2     <= off_p1;
    end
  end

  // vld_p2 marks the cycle right after a W commit, when the RAM output
  // still belongs to the committed load; afterwards the held copy is used.
  assign ext_now = load_ext(rdata_a, off_p2, ld_p2);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      hold_p2 <= 32'd0;
    end else begin
      vld_p2 <= flush_w | commit_m | commit_pend;
      if (vld_p2) hold_p2 <= ext_now;
    end
  end

  assign result_w = (ld_p2 != LD_NONE) ? (vld_p2 ? ext_now : hold_p2) : res_p2;

  logic unused_ok;
  assign unused_ok = &{1'b0, addr_m[31:ADDR_W+2], addr_dbg[31:ADDR_W+2], addr_dbg[1:0],
                       we_dbg, wdata_dbg, rdata_b};

endmodule

// File: tb/tb_wb_seg_mem.sv
module tb_wb_seg_mem;
  import wb_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, clear, en2, clear2;
  logic [31:0] addr_m, wdata_m, result_m, addr_dbg, wdata_dbg;
  logic [1:0]  store_m;
  logic [2:0]  load_m;
  logic [4:0]  rd_m;
  logic        regwrite_m;
  logic [3:0]  we_dbg;

  logic [31:0] rdata_dbg, result_w, rdata_dbg2, result_w2;
  logic [4:0]  rd_w, rd_w2;
  logic        busy, regwrite_w, misalign_w, busy2, regwrite_w2, misalign_w2;

  int n_tests = 0;
  int n_fail  = 0;

  wb_seg_mem #(.ADDR_W(12), .RD_LAT(1), .DBG_EN(1)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .addr_m(addr_m), .wdata_m(wdata_m), .store_m(store_m), .load_m(load_m),
    .result_m(result_m), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .addr_dbg(addr_dbg), .wdata_dbg(wdata_dbg), .we_dbg(we_dbg), .rdata_dbg(rdata_dbg),
    .busy(busy), .result_w(result_w), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .misalign_w(misalign_w)
  );

  wb_seg_mem #(.ADDR_W(12), .RD_LAT(2), .DBG_EN(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .clear(clear2),
    .addr_m(addr_m), .wdata_m(wdata_m), .store_m(store_m), .load_m(load_m),
    .result_m(result_m), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .addr_dbg(addr_dbg), .wdata_dbg(wdata_dbg), .we_dbg(we_dbg), .rdata_dbg(rdata_dbg2),
    .busy(busy2), .result_w(result_w2), .rd_w(rd_w2), .regwrite_w(regwrite_w2),
    .misalign_w(misalign_w2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] st, input logic [2:0] ld, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] res, input logic [4:0] rd,
                        input logic rw);
    store_m = st; load_m = ld; addr_m = a; wdata_m = wd;
    result_m = res; rd_m = rd; regwrite_m = rw;
  endtask

  // One accepted MEM op into the RD_LAT=1 instance; W outputs valid on return.
  task automatic op(input logic [1:0] st, input logic [2:0] ld, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] res, input logic [4:0] rd,
                    input logic rw);
    set_op(st, ld, a, wd, res, rd, rw);
    en = 1'b1; clear = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; en2 = 1'b0; clear2 = 1'b0;
    addr_dbg = 32'd0; wdata_dbg = 32'd0; we_dbg = 4'd0;
    set_op(MEM_NONE, LD_NONE, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    step(); step();
    rst = 1'b0;
    chk("rst_result", result_w, 32'd0);
    chk("rst_rd", 32'(rd_w), 32'd0);
    chk("rst_rw", 32'(regwrite_w), 32'd0);
    chk("rst_mis", 32'(misalign_w), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);

    // Word store then sign/zero extended sub-word loads
    op(MEM_W, LD_NONE, 32'h100, 32'hAABBCCDD, 32'h0000_0100, 5'd0, 1'b0);
    chk("sw_alu_pass", result_w, 32'h0000_0100);
    chk("sw_mis", 32'(misalign_w), 32'd0);
    op(MEM_NONE, LB, 32'h103, 32'd0, 32'h103, 5'd5, 1'b1);
    chk("lb_103", result_w, 32'hFFFFFFAA);
    chk("lb_rd", 32'(rd_w), 32'd5);
    chk("lb_rw", 32'(regwrite_w), 32'd1);
    op(MEM_NONE, LBU, 32'h101, 32'd0, 32'h101, 5'd5, 1'b1);
    chk("lbu_101", result_w, 32'h000000CC);
    op(MEM_NONE, LH, 32'h102, 32'd0, 32'h102, 5'd5, 1'b1);
    chk("lh_102", result_w, 32'hFFFFAABB);
    op(MEM_NONE, LHU, 32'h100, 32'd0, 32'h100, 5'd5, 1'b1);
    chk("lhu_100", result_w, 32'h0000CCDD);

    // Half and byte stores touch only their lanes
    op(MEM_H, LD_NONE, 32'h102, 32'hFFFF1234, 32'd0, 5'd0, 1'b0);
    op(MEM_NONE, LW, 32'h100, 32'd0, 32'd0, 5'd6, 1'b1);
    chk("sh_lw", result_w, 32'h1234CCDD);
    op(MEM_B, LD_NONE, 32'h101, 32'h0000015A, 32'd0, 5'd0, 1'b0);
    op(MEM_NONE, LW, 32'h100, 32'd0, 32'd0, 5'd6, 1'b1);
    chk("sb_lw", result_w, 32'h12345ADD);

    // Misaligned accesses
    op(MEM_W, LD_NONE, 32'h101, 32'h11111111, 32'h55, 5'd0, 1'b0);
    chk("sw_mis_flag", 32'(misalign_w), 32'd1);
    op(MEM_NONE, LW, 32'h100, 32'd0, 32'd0, 5'd6, 1'b1);
    chk("sw_mis_nowrite", result_w, 32'h12345ADD);
    chk("mis_one_cycle", 32'(misalign_w), 32'd0);
    op(MEM_NONE, LH, 32'h103, 32'd0, 32'd0, 5'd7, 1'b1);
    chk("lh_mis_rw", 32'(regwrite_w), 32'd0);
    chk("lh_mis_flag", 32'(misalign_w), 32'd1);

    // Flush: W cleared, store under clear writes nothing
    set_op(MEM_W, LD_NONE, 32'h100, 32'hDEADBEEF, 32'h99, 5'd9, 1'b1);
    en = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_result", result_w, 32'd0);
    chk("clr_rd", 32'(rd_w), 32'd0);
    chk("clr_rw", 32'(regwrite_w), 32'd0);
    op(MEM_NONE, LW, 32'h100, 32'd0, 32'd0, 5'd6, 1'b1);
    chk("clr_nowrite", result_w, 32'h12345ADD);

    // Stall: W holds the load value while port B rewrites the word
    op(MEM_NONE, LW, 32'h100, 32'd0, 32'd0, 5'd3, 1'b1);
    chk("stall_pre", result_w, 32'h12345ADD);
    en = 1'b0;
    addr_dbg = 32'h100; wdata_dbg = 32'hCAFEF00D; we_dbg = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", result_w, 32'h12345ADD);
      chk("stall_rd", 32'(rd_w), 32'd3);
    end
    we_dbg = 4'h0;
    chk("dbg_read", rdata_dbg, 32'hCAFEF00D);
    op(MEM_NONE, LW, 32'h100, 32'd0, 32'd0, 5'd3, 1'b1);
    chk("dbg_write_seen", result_w, 32'hCAFEF00D);

    // Same-word collision: port A wins its lanes
    set_op(MEM_H, LD_NONE, 32'h200, 32'h0000BEEF, 32'd0, 5'd0, 1'b0);
    addr_dbg = 32'h200; wdata_dbg = 32'h11223344; we_dbg = 4'hF;
    en = 1'b1;
    step();
    we_dbg = 4'h0;
    op(MEM_NONE, LW, 32'h200, 32'd0, 32'd0, 5'd1, 1'b1);
    chk("collide", result_w, 32'h1122BEEF);
    op(MEM_NONE, LW, 32'h4200, 32'd0, 32'd0, 5'd1, 1'b1);
    chk("wrap", result_w, 32'h1122BEEF);

    // Reset mid-load
    op(MEM_NONE, LW, 32'h100, 32'd0, 32'd0, 5'd8, 1'b1);
    set_op(MEM_NONE, LW, 32'h200, 32'd0, 32'd0, 5'd10, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstm_result", result_w, 32'd0);
    chk("rstm_rd", 32'(rd_w), 32'd0);
    chk("rstm_rw", 32'(regwrite_w), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    op(MEM_NONE, LW, 32'h100, 32'd0, 32'd0, 5'd8, 1'b1);
    chk("rstm_ram_kept", result_w, 32'hCAFEF00D);
    en = 1'b0;

    // RD_LAT=2 instance
    set_op(MEM_NONE, LW, 32'h100, 32'd0, 32'd0, 5'd4, 1'b1);
    en2 = 1'b1;
    step();
    en2 = 1'b0;
    chk("l2_busy", 32'(busy2), 32'd1);
    chk("l2_w_not_yet", 32'(rd_w2), 32'd0);
    step();
    chk("l2_busy_drop", 32'(busy2), 32'd0);
    chk("l2_result", result_w2, 32'hCAFEF00D);
    chk("l2_rd", 32'(rd_w2), 32'd4);
    chk("l2_rw", 32'(regwrite_w2), 32'd1);
    step();
    chk("l2_busy_once", 32'(busy2), 32'd0);
    chk("l2_hold", result_w2, 32'hCAFEF00D);
    set_op(MEM_NONE, LB, 32'h103, 32'd0, 32'd0, 5'd4, 1'b1);
    en2 = 1'b1;
    step();
    en2 = 1'b0;
    step();
    chk("l2_lb", result_w2, 32'hFFFFFFCA);

    // Clear during WAIT aborts the load
    set_op(MEM_NONE, LW, 32'h200, 32'd0, 32'd0, 5'd6, 1'b1);
    en2 = 1'b1;
    step();
    chk("l2c_busy", 32'(busy2), 32'd1);
    en2 = 1'b0; clear2 = 1'b1;
    step();
    clear2 = 1'b0;
    chk("l2c_busy_drop", 32'(busy2), 32'd0);
    chk("l2c_rw", 32'(regwrite_w2), 32'd0);
    chk("l2c_result", result_w2, 32'd0);
    chk("l2c_rd", 32'(rd_w2), 32'd0);
    step();
    chk("l2c_idle", 32'(busy2), 32'd0);
    set_op(MEM_NONE, LD_NONE, 32'd0, 32'd0, 32'h77, 5'd2, 1'b1);
    en2 = 1'b1;
    step();
    en2 = 1'b0;
    chk("l2c_next_busy", 32'(busy2), 32'd0);
    chk("l2c_next_res", result_w2, 32'h77);
    chk("l2c_next_rd", 32'(rd_w2), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
